sipo_deser: RTL and testbench

//  Parametrised serial-in, parallel-out deserialiser with LANES bits per beat.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_out_buf.sv | 47 ++++
 rtl/sipo_deser.sv | 138 +++++++++++++
 tb/tb_sipo_deser.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser deserialiser.
package sipo_pkg;

    // Deserialiser FSM states; PAR is only reachable with SIPO_PARITY_EN defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } sipo_state_e;

    // Beat counter width; one spare bit so BEATS=1 still gets a 1-bit counter.
    function automatic int beat_cnt_w(input int width, input int lanes);
        return $clog2(width / lanes) + 1;
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words.
// A word offered while the register is still full is dropped and the
// sticky drop flag is raised; a raise wins over a same-cycle clear.
module sipo_out_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             clr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             drop
);

    logic can_take;

    // Empty, or being drained this cycle, so a new word may replace it.
    assign can_take = !valid || ready;

    // Holding register: load on space, otherwise clear valid once consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && can_take) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (load && !can_take) begin
            drop <= 1'b1;
        end else if (clr) begin
            drop <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserialiser, LANES bits per beat, WIDTH-bit words.
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity beat per
// word, the PAR state and the sticky parity_err output.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LANES-1:0] in_data,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_ovf,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = beat_cnt_w(WIDTH, LANES);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if ((WIDTH % LANES) != 0 || WIDTH < LANES) begin : g_bad_cfg
        $error("sipo_deser: WIDTH must be a non-zero multiple of LANES");
    end

    logic [WIDTH-1:0] sh, sh_next, base_sh, shifted, word;
    logic [CW-1:0]    cnt, cnt_next, base_cnt;
    sipo_state_e      state, state_next, base_state;
    logic             word_done;
`ifdef SIPO_PARITY_EN
    logic             par_bad;
`endif

    // Beat acceptance, framing and word completion.
    always_comb begin
        // frame_start behaves as if the frame were already idle this cycle.
        base_sh    = frame_start ? '0   : sh;
        base_cnt   = frame_start ? '0   : cnt;
        base_state = frame_start ? IDLE : state;

        if (MSB_FIRST != 0) begin
            shifted = WIDTH'({base_sh, in_data});
        end else begin
            shifted = WIDTH'({in_data, base_sh} >> LANES);
        end

        sh_next    = base_sh;
        cnt_next   = base_cnt;
        state_next = base_state;
        word_done  = 1'b0;
        word       = shifted;
`ifdef SIPO_PARITY_EN
        par_bad    = 1'b0;
`endif

        if (in_valid) begin
`ifdef SIPO_PARITY_EN
            if (base_state == PAR) begin
                // Parity beat: the word has been parked in sh since the last data beat.
                word_done  = 1'b1;
                word       = base_sh;
                par_bad    = (^base_sh) ^ in_data[0];
                state_next = IDLE;
                cnt_next   = '0;
            end else
`endif
            begin
                sh_next = shifted;
                if (base_cnt == LAST) begin
                    cnt_next = '0;
`ifdef SIPO_PARITY_EN
                    state_next = PAR;
`else
                    word_done  = 1'b1;
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next   = base_cnt + CW'(1);
                    state_next = SHIFT;
                end
            end
        end
    end

    // Shifter, beat counter and FSM state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh    <= '0;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            sh    <= sh_next;
            cnt   <= cnt_next;
            state <= state_next;
        end
    end

`ifdef SIPO_PARITY_EN
    // Sticky parity error; a new error wins over a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (word_done && par_bad) begin
            parity_err <= 1'b1;
        end else if (clr_ovf) begin
            parity_err <= 1'b0;
        end
    end

    assign busy = (cnt != '0) || (state == PAR);
`else
    assign busy = (cnt != '0);
`endif

    sipo_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clock    (clock),
        .reset    (reset),
        .load     (word_done),
        .load_data(word),
        .ready    (out_ready),
        .clr      (clr_ovf),
        .data     (out_data),
        .valid    (out_valid),
        .drop     (overflow)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: three instances covering 1-lane MSB-first,
// 4-lane LSB-first and the single-beat-word (WIDTH == LANES) corner.
// Honours SIPO_PARITY_EN when defined.
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef logic       bits16_t [16];
    typedef logic [3:0] nib4_t   [4];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic out_ready = 1'b1;
    logic clr_ovf = 1'b0;

    logic [0:0]  in_data1 = '0;
    logic        v1 = 1'b0;
    logic [15:0] od1;
    logic        ov1, of1, b1;

    logic [3:0]  in_data2 = '0;
    logic        v2 = 1'b0;
    logic [15:0] od2;
    logic        ov2, of2, b2;

    logic [7:0]  in_data3 = '0;
    logic        v3 = 1'b0;
    logic [7:0]  od3;
    logic        ov3, of3, b3;

`ifdef SIPO_PARITY_EN
    logic pe1, pe2, pe3;
`endif

    sipo_deser #(.WIDTH(16), .LANES(1), .MSB_FIRST(1)) d1 (
        .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(v1),
        .frame_start(frame_start), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .overflow(of1), .clr_ovf(clr_ovf),
`ifdef SIPO_PARITY_EN
        .parity_err(pe1),
`endif
        .busy(b1)
    );

    sipo_deser #(.WIDTH(16), .LANES(4), .MSB_FIRST(0)) d2 (
        .clock(clock), .reset(reset), .in_data(in_data2), .in_valid(v2),
        .frame_start(frame_start), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
        .overflow(of2), .clr_ovf(clr_ovf),
`ifdef SIPO_PARITY_EN
        .parity_err(pe2),
`endif
        .busy(b2)
    );

    sipo_deser #(.WIDTH(8), .LANES(8), .MSB_FIRST(1)) d3 (
        .clock(clock), .reset(reset), .in_data(in_data3), .in_valid(v3),
        .frame_start(frame_start), .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
        .overflow(of3), .clr_ovf(clr_ovf),
`ifdef SIPO_PARITY_EN
        .parity_err(pe3),
`endif
        .busy(b3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: first beat is the most significant bit.
    function automatic logic [15:0] model_msb(input bits16_t b);
        int unsigned w = 0;
        for (int i = 0; i < 16; i++) w = w * 2 + int'(b[i]);
        return 16'(w);
    endfunction

    // Reference: beat i carries weight 16**i.
    function automatic logic [15:0] model_lsb4(input nib4_t nb);
        int unsigned w = 0;
        int unsigned wt = 1;
        for (int i = 0; i < 4; i++) begin
            w  = w + int'(nb[i]) * wt;
            wt = wt * 16;
        end
        return 16'(w);
    endfunction

    function automatic logic even_par(input logic [15:0] w);
        return logic'($countones(w) % 2);
    endfunction

    function automatic bits16_t to_bits(input logic [15:0] w);
        bits16_t b;
        for (int i = 0; i < 16; i++) b[i] = w[15-i];
        return b;
    endfunction

    task automatic send1(input bits16_t b, input int maxgap, input logic do_par,
                         input logic pbit);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin v1 = 1'b0; tick(); end
            v1 = 1'b1;
            in_data1 = b[i];
            tick();
        end
        if (PAR_EN && do_par) begin
            v1 = 1'b1;
            in_data1 = pbit;
            tick();
        end
        v1 = 1'b0;
    endtask

    task automatic send2(input nib4_t nb, input int maxgap, input logic pbit);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin v2 = 1'b0; tick(); end
            v2 = 1'b1;
            in_data2 = nb[i];
            tick();
        end
        if (PAR_EN) begin
            v2 = 1'b1;
            in_data2 = {3'($urandom), pbit};
            tick();
        end
        v2 = 1'b0;
    endtask

    bits16_t     bv;
    nib4_t       nb;
    logic [15:0] expw;
    logic        pb;
    logic [7:0]  beat, beat_a;
`ifdef SIPO_PARITY_EN
    logic        pe_exp;
`endif

    initial begin
        // Reset state
        tick();
        chk("rst od1", 32'(od1), 32'd0);
        chk("rst ov1", 32'(ov1), 32'd0);
        chk("rst of1", 32'(of1), 32'd0);
        chk("rst b1", 32'(b1), 32'd0);
        chk("rst ov2", 32'(ov2), 32'd0);
        chk("rst ov3", 32'(ov3), 32'd0);
`ifdef SIPO_PARITY_EN
        chk("rst pe1", 32'(pe1), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // 1: A5C3 MSB first, one-cycle valid, latency 1 after the final beat
        bv = to_bits(16'hA5C3);
        for (int i = 0; i < 16; i++) begin
            v1 = 1'b1;
            in_data1 = bv[i];
            tick();
            if (i == 14) chk("t1 early valid", 32'(ov1), 32'd0);
        end
        if (PAR_EN) begin
            chk("t1 par busy", 32'(b1), 32'd1);
            in_data1 = even_par(16'hA5C3);
            tick();
        end
        v1 = 1'b0;
        chk("t1 valid", 32'(ov1), 32'd1);
        chk("t1 data", 32'(od1), 32'h0000A5C3);
        tick();
        chk("t1 valid drop", 32'(ov1), 32'd0);

        // 2: 4 lanes LSB first, nibbles 3,C,5,A
        nb = '{4'h3, 4'hC, 4'h5, 4'hA};
        for (int i = 0; i < 4; i++) begin
            v2 = 1'b1;
            in_data2 = nb[i];
            tick();
            if (i < 3) chk("t2 busy", 32'(b2), 32'd1);
        end
        chk("t2 busy end", 32'(b2), 32'(PAR_EN));
        if (PAR_EN) begin
            in_data2 = {3'b0, even_par(16'hA5C3)};
            tick();
        end
        v2 = 1'b0;
        chk("t2 data", 32'(od2), 32'(model_lsb4(nb)));
        chk("t2 valid", 32'(ov2), 32'd1);
        chk("t2 busy idle", 32'(b2), 32'd0);
        tick();

        // 3: held word, second word dropped, overflow then clear
        out_ready = 1'b0;
        send1(to_bits(16'h1111), 2, 1'b1, 1'b0);
        chk("t3 first valid", 32'(ov1), 32'd1);
        chk("t3 no ovf yet", 32'(of1), 32'd0);
        send1(to_bits(16'h2222), 2, 1'b1, 1'b0);
        chk("t3 held data", 32'(od1), 32'h00001111);
        chk("t3 ovf", 32'(of1), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3 ovf clr", 32'(of1), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t3 consumed", 32'(ov1), 32'd0);

        // 4: frame_start resync mid-word with a coincident beat
        for (int i = 0; i < 7; i++) begin
            v1 = 1'b1;
            in_data1 = 1'($urandom);
            tick();
        end
        bv = to_bits(16'hBEEF);
        frame_start = 1'b1;
        v1 = 1'b1;
        in_data1 = bv[0];
        tick();
        frame_start = 1'b0;
        chk("t4 busy", 32'(b1), 32'd1);
        for (int i = 1; i < 16; i++) begin
            in_data1 = bv[i];
            tick();
            if (i == 8) chk("t4 no early word", 32'(ov1), 32'd0);
        end
        if (PAR_EN) begin
            in_data1 = even_par(16'hBEEF);
            tick();
        end
        v1 = 1'b0;
        chk("t4 data", 32'(od1), 32'h0000BEEF);
        chk("t4 valid", 32'(ov1), 32'd1);
        chk("t4 ovf", 32'(of1), 32'd0);
        tick();

        // 5: asynchronous reset mid-word
        for (int i = 0; i < 9; i++) begin
            v1 = 1'b1;
            in_data1 = 1'($urandom);
            tick();
        end
        v1 = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5 rst od1", 32'(od1), 32'd0);
        chk("t5 rst ov1", 32'(ov1), 32'd0);
        chk("t5 rst of1", 32'(of1), 32'd0);
        chk("t5 rst b1", 32'(b1), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send1(to_bits(16'h0F0F), 1, 1'b1, even_par(16'h0F0F));
        chk("t5 data", 32'(od1), 32'h00000F0F);
        chk("t5 valid", 32'(ov1), 32'd1);
        tick();

`ifdef SIPO_PARITY_EN
        // 6: parity checking
        send1(to_bits(16'h0001), 0, 1'b1, 1'b1);
        chk("t6 data ok", 32'(od1), 32'h00000001);
        chk("t6 pe clean", 32'(pe1), 32'd0);
        send1(to_bits(16'h0003), 0, 1'b1, 1'b1);
        chk("t6 data bad", 32'(od1), 32'h00000003);
        chk("t6 valid bad", 32'(ov1), 32'd1);
        chk("t6 pe set", 32'(pe1), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t6 pe clr", 32'(pe1), 32'd0);
        // frame_start while waiting for the parity beat discards the word
        send1(to_bits(16'h1234), 0, 1'b0, 1'b0);
        chk("t6 in par", 32'(b1), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t6 par discarded", 32'(b1), 32'd0);
        chk("t6 no word", 32'(ov1), 32'd0);
        send1(to_bits(16'h5678), 0, 1'b1, even_par(16'h5678));
        chk("t6 after discard", 32'(od1), 32'h00005678);
        tick();
`endif

        // Randomised words, lane-1 MSB-first
`ifdef SIPO_PARITY_EN
        pe_exp = 1'b0;
`endif
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 16; i++) bv[i] = 1'($urandom);
            expw = model_msb(bv);
            pb = (($urandom_range(3, 0)) == 0) ? ~even_par(expw) : even_par(expw);
            send1(bv, 2, 1'b1, pb);
            chk("r1 valid", 32'(ov1), 32'd1);
            chk("r1 data", 32'(od1), 32'(expw));
`ifdef SIPO_PARITY_EN
            pe_exp = pe_exp | (pb != even_par(expw));
            chk("r1 pe", 32'(pe1), 32'(pe_exp));
`endif
        end
        tick();

        // Randomised words, 4 lanes LSB-first
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) nb[i] = 4'($urandom);
            expw = model_lsb4(nb);
            send2(nb, 2, even_par(expw));
            chk("r2 valid", 32'(ov2), 32'd1);
            chk("r2 data", 32'(od2), 32'(expw));
        end
        tick();

        // Single-beat words: every data beat is a complete word
        for (int k = 0; k < 4; k++) begin
            beat = 8'($urandom);
            v3 = 1'b1;
            in_data3 = beat;
            tick();
`ifdef SIPO_PARITY_EN
            chk("s3 par busy", 32'(b3), 32'd1);
            in_data3 = {7'b0, ^beat};
            tick();
`endif
            chk("s3 valid", 32'(ov3), 32'd1);
            chk("s3 data", 32'(od3), 32'(beat));
            chk("s3 busy", 32'(b3), 32'd0);
        end
        v3 = 1'b0;
        tick();
        chk("s3 drained", 32'(ov3), 32'd0);
        out_ready = 1'b0;
        beat_a = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            beat = (k == 0) ? beat_a : ~beat_a;
            v3 = 1'b1;
            in_data3 = beat;
            tick();
            if (PAR_EN) begin
                in_data3 = {7'b0, ^beat};
                tick();
            end
        end
        v3 = 1'b0;
        tick();
        chk("s3 held", 32'(od3), 32'(beat_a));
        chk("s3 ovf", 32'(of3), 32'd1);
        out_ready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
